// File: rtl/fifo_sdram_pkg.sv
// Shared types and defaults for the camera FIFO to SDRAM burst writer.
package fifo_sdram_pkg;

   // Burst writer control states.
   typedef enum logic [1:0] {
      ST_FILL    = 2'd0,
      ST_REQ     = 2'd1,
      ST_WRITE   = 2'd2,
      ST_ADVANCE = 2'd3
   } wr_state_e;

   localparam int DEF_DATA_WIDTH  = 16;
   localparam int DEF_ADDR_WIDTH  = 24;
   localparam int DEF_BURST_LEN   = 8;

   // Frame geometry: one 16-bit word per pixel, 640x480.
   localparam int FRAME_COLS      = 640;
   localparam int FRAME_ROWS      = 480;
   localparam int DEF_FRAME_WORDS = FRAME_COLS * FRAME_ROWS;
   localparam int DEF_BASE_ADDR   = 0;

endpackage

// File: rtl/burst_stage_buf.sv
// Burst staging register file: synchronous write port, combinational read port.
module burst_stage_buf #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 16,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             clear_i,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   // Store one FIFO word per write; cleared so the data output reads 0 after reset.
   always_ff @(posedge clk_i) begin
      if (clear_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_sdram_burst_writer.sv
// Drains the camera FIFO into a staging buffer and writes it to SDRAM as one
// burst at a time, walking linear frame addresses that wrap at FRAME_WORDS.
//
// Handshakes: a FIFO word is popped on every cycle where Fifo_ReadEn_out and
// ~Fifo_Empty_in are both high and arrives on Fifo_Data_in one cycle later.
// Sdram_WrReq_out stays high with a stable address until the single-cycle
// Sdram_WrAck_in; each Sdram_WrDataReq_in during the burst (including one in
// the ack cycle) consumes the word currently on Sdram_WrData_out.
module fifo_sdram_burst_writer
   import fifo_sdram_pkg::*;
#(
   parameter int          DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int          ADDR_WIDTH  = DEF_ADDR_WIDTH,
   parameter int          BURST_LEN   = DEF_BURST_LEN,
   parameter int unsigned BASE_ADDR   = DEF_BASE_ADDR,
   parameter int unsigned FRAME_WORDS = DEF_FRAME_WORDS
) (
   input  logic                  Clk,
   input  logic                  Clear_in,
   input  logic                  Fifo_Empty_in,
   input  logic [DATA_WIDTH-1:0] Fifo_Data_in,
   output logic                  Fifo_ReadEn_out,
   input  logic                  Frame_Start_in,
   output logic                  Sdram_WrReq_out,
   output logic [ADDR_WIDTH-1:0] Sdram_WrAddr_out,
   input  logic                  Sdram_WrAck_in,
   input  logic                  Sdram_WrDataReq_in,
   output logic [DATA_WIDTH-1:0] Sdram_WrData_out,
   output logic                  Burst_Done_out,
   output logic                  Frame_Done_out,
   output logic [1:0]            Dbg_State_out
);

   localparam int                  IDX_W     = $clog2(BURST_LEN);
   localparam int                  CNT_W     = IDX_W + 1;
   localparam logic [CNT_W-1:0]    BURST_CNT = CNT_W'(BURST_LEN);
   localparam logic [ADDR_WIDTH-1:0] BASE_A  = ADDR_WIDTH'(BASE_ADDR);
   localparam logic [ADDR_WIDTH-1:0] STEP_A  = ADDR_WIDTH'(BURST_LEN);
   // Start address of the final burst of a frame.
   localparam logic [ADDR_WIDTH-1:0] LAST_A  = ADDR_WIDTH'(BASE_ADDR + FRAME_WORDS - BURST_LEN);

   wr_state_e             state_q;
   logic [CNT_W-1:0]      issued_q, filled_q, wr_idx_q;
   logic                  rd_valid_q;
   logic                  fs_pend_q;
   logic [ADDR_WIDTH-1:0] cur_addr_q;
   logic                  req_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  burst_done_q, frame_done_q;

   logic                  rd_grant_d;
   logic                  buf_we_d;
   logic                  fs_any_d;

   // Reads are granted combinationally so the FIFO's own gating never drops one.
   assign rd_grant_d = (state_q == ST_FILL) && !Fifo_Empty_in && (issued_q < BURST_CNT);
   // A frame restart in FILL discards the word arriving in that cycle.
   assign buf_we_d   = rd_valid_q && (state_q == ST_FILL) && !Frame_Start_in;
   assign fs_any_d   = fs_pend_q || Frame_Start_in;

   burst_stage_buf #(
      .DEPTH (BURST_LEN),
      .WIDTH (DATA_WIDTH)
   ) u_buf (
      .clk_i   (Clk),
      .clear_i (Clear_in),
      .we_i    (buf_we_d),
      .waddr_i (filled_q[IDX_W-1:0]),
      .wdata_i (Fifo_Data_in),
      .raddr_i (wr_idx_q[IDX_W-1:0]),
      .rdata_o (Sdram_WrData_out)
   );

   // Control FSM, fill/write counters, address generator and registered outputs.
   always_ff @(posedge Clk) begin
      if (Clear_in) begin
         state_q      <= ST_FILL;
         issued_q     <= '0;
         filled_q     <= '0;
         wr_idx_q     <= '0;
         rd_valid_q   <= 1'b0;
         fs_pend_q    <= 1'b0;
         cur_addr_q   <= BASE_A;
         req_q        <= 1'b0;
         addr_q       <= BASE_A;
         burst_done_q <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         burst_done_q <= 1'b0;
         frame_done_q <= 1'b0;
         rd_valid_q   <= rd_grant_d;
         case (state_q)
            ST_FILL, ST_REQ: begin
               if (state_q == ST_REQ && Sdram_WrAck_in) begin
                  // Ack beats a simultaneous frame start; the restart is deferred.
                  state_q <= ST_WRITE;
                  req_q   <= 1'b0;
                  if (Sdram_WrDataReq_in) wr_idx_q <= wr_idx_q + 1'b1;
                  if (Frame_Start_in)     fs_pend_q <= 1'b1;
               end else if (Frame_Start_in) begin
                  // Abandon the partial or pending burst and restart the frame.
                  state_q    <= ST_FILL;
                  issued_q   <= '0;
                  filled_q   <= '0;
                  wr_idx_q   <= '0;
                  rd_valid_q <= 1'b0;
                  fs_pend_q  <= 1'b0;
                  cur_addr_q <= BASE_A;
                  req_q      <= 1'b0;
                  addr_q     <= BASE_A;
               end else if (state_q == ST_FILL) begin
                  if (rd_grant_d) issued_q <= issued_q + 1'b1;
                  if (rd_valid_q) filled_q <= filled_q + 1'b1;
                  if (filled_q == BURST_CNT) begin
                     state_q <= ST_REQ;
                     req_q   <= 1'b1;
                     addr_q  <= cur_addr_q;
                  end
               end
            end
            ST_WRITE: begin
               if (Frame_Start_in) fs_pend_q <= 1'b1;
               if (Sdram_WrDataReq_in) begin
                  wr_idx_q <= wr_idx_q + 1'b1;
                  if (wr_idx_q == BURST_CNT - 1'b1) state_q <= ST_ADVANCE;
               end
            end
            ST_ADVANCE: begin
               burst_done_q <= 1'b1;
               if (fs_any_d) begin
                  cur_addr_q <= BASE_A;
               end else if (cur_addr_q == LAST_A) begin
                  cur_addr_q   <= BASE_A;
                  frame_done_q <= 1'b1;
               end else begin
                  cur_addr_q <= cur_addr_q + STEP_A;
               end
               issued_q  <= '0;
               filled_q  <= '0;
               wr_idx_q  <= '0;
               fs_pend_q <= 1'b0;
               state_q   <= ST_FILL;
            end
            default: state_q <= ST_FILL;
         endcase
      end
   end

   assign Fifo_ReadEn_out  = rd_grant_d;
   assign Sdram_WrReq_out  = req_q;
   assign Sdram_WrAddr_out = addr_q;
   assign Burst_Done_out   = burst_done_q;
   assign Frame_Done_out   = frame_done_q;
   assign Dbg_State_out    = state_q;

endmodule

// File: tb/tb_fifo_sdram_burst_writer.sv
// Bench for fifo_sdram_burst_writer: FIFO and SDRAM controller models plus a
// frame-level reference of which words and addresses each burst must carry.
module tb_fifo_sdram_burst_writer;

  localparam int DW   = 16;
  localparam int AW   = 24;
  localparam int BL   = 8;
  localparam int FW   = 32;
  localparam int BASE = 0;

  logic          Clk = 1'b0;
  logic          Clear_in;
  logic          Fifo_Empty_in;
  logic [DW-1:0] Fifo_Data_in;
  logic          Fifo_ReadEn_out;
  logic          Frame_Start_in;
  logic          Sdram_WrReq_out;
  logic [AW-1:0] Sdram_WrAddr_out;
  logic          Sdram_WrAck_in;
  logic          Sdram_WrDataReq_in;
  logic [DW-1:0] Sdram_WrData_out;
  logic          Burst_Done_out;
  logic          Frame_Done_out;
  logic [1:0]    Dbg_State_out;

  fifo_sdram_burst_writer #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .BURST_LEN   (BL),
    .BASE_ADDR   (BASE),
    .FRAME_WORDS (FW)
  ) dut (
    .Clk                (Clk),
    .Clear_in           (Clear_in),
    .Fifo_Empty_in      (Fifo_Empty_in),
    .Fifo_Data_in       (Fifo_Data_in),
    .Fifo_ReadEn_out    (Fifo_ReadEn_out),
    .Frame_Start_in     (Frame_Start_in),
    .Sdram_WrReq_out    (Sdram_WrReq_out),
    .Sdram_WrAddr_out   (Sdram_WrAddr_out),
    .Sdram_WrAck_in     (Sdram_WrAck_in),
    .Sdram_WrDataReq_in (Sdram_WrDataReq_in),
    .Sdram_WrData_out   (Sdram_WrData_out),
    .Burst_Done_out     (Burst_Done_out),
    .Frame_Done_out     (Frame_Done_out),
    .Dbg_State_out      (Dbg_State_out)
  );

  // ---------------- clock / reset ----------------
  always #5 Clk = ~Clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          failures = 0;
  logic [DW-1:0] fifo_q[$];     // words waiting in the camera FIFO
  logic [DW-1:0] exp_q[$];      // words popped and owed to the current burst
  bit          done_exp_q[$];   // per completed burst: expected Frame_Done
  int          model_addr;
  bit          in_burst, acked, fs_pend, expect_drop, have_data;
  int          sent, wait_cnt, ack_delay, bursts_done;
  logic [DW-1:0] data_next, next_word;

  // stimulus modes
  bit seq_mode, stray_mode, rand_ack, gap_tog;
  bit fs_req_arm, fs_wr_arm, fs_ack_arm;
  int empty_mode, strb_mode, strb_phase;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    fifo_q.delete();
    exp_q.delete();
    done_exp_q.delete();
    model_addr  = BASE;
    in_burst    = 0;
    acked       = 0;
    fs_pend     = 0;
    expect_drop = 0;
    have_data   = 0;
    sent        = 0;
    wait_cnt    = 0;
  endtask

  // Hold Clear_in for a few edges, check reset values, release.
  task automatic do_reset();
    Clear_in           = 1'b1;
    Fifo_Empty_in      = 1'b1;
    Fifo_Data_in       = '0;
    Frame_Start_in     = 1'b0;
    Sdram_WrAck_in     = 1'b0;
    Sdram_WrDataReq_in = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check("rst_req",        Sdram_WrReq_out,  0);
    check("rst_addr",       Sdram_WrAddr_out, BASE);
    check("rst_burst_done", Burst_Done_out,   0);
    check("rst_frame_done", Frame_Done_out,   0);
    check("rst_data",       Sdram_WrData_out, 0);
    check("rst_rden",       Fifo_ReadEn_out,  0);
    check("rst_state",      Dbg_State_out,    0);
    @(posedge Clk);
    #1;
    Clear_in = 1'b0;
    model_reset();
  endtask

  // ---------------- observation (negedge) ----------------
  task automatic observe();
    logic [DW-1:0] w;
    if (expect_drop) begin
      check("fs_req_drop", Sdram_WrReq_out, 0);
      expect_drop = 0;
    end
    if (Burst_Done_out) begin
      check("burst_done_expected", done_exp_q.size() > 0, 1);
      if (done_exp_q.size() > 0) check("frame_done", Frame_Done_out, done_exp_q.pop_front());
    end else if (Frame_Done_out) begin
      check("frame_done_alone", Frame_Done_out, 0);
    end

    if (!in_burst) begin
      if (Sdram_WrReq_out) begin
        in_burst  = 1;
        acked     = 0;
        sent      = 0;
        wait_cnt  = 0;
        fs_pend   = 0;
        ack_delay = rand_ack ? $urandom_range(1, 5) : 2;
        check("req_addr", Sdram_WrAddr_out, model_addr);
        check("req_full", exp_q.size(), BL);
      end
    end else if (!acked) begin
      check("req_hold",      Sdram_WrReq_out,  1);
      check("req_addr_hold", Sdram_WrAddr_out, model_addr);
    end else begin
      check("req_low", Sdram_WrReq_out, 0);
    end

    // Events the DUT will act on at the coming rising edge.
    if (in_burst && !acked) begin
      if (Sdram_WrAck_in) begin
        acked = 1;
      end else if (Frame_Start_in) begin
        exp_q.delete();
        model_addr  = BASE;
        in_burst    = 0;
        expect_drop = 1;
      end
    end
    if (in_burst && acked && Frame_Start_in) fs_pend = 1;
    if (in_burst && acked && Sdram_WrDataReq_in && sent < BL) begin
      check("wr_data", Sdram_WrData_out, exp_q.pop_front());
      sent++;
      if (sent == BL) begin
        if (fs_pend) begin
          model_addr = BASE;
          done_exp_q.push_back(1'b0);
        end else if (model_addr + BL == BASE + FW) begin
          model_addr = BASE;
          done_exp_q.push_back(1'b1);
        end else begin
          model_addr = model_addr + BL;
          done_exp_q.push_back(1'b0);
        end
        fs_pend  = 0;
        in_burst = 0;
        bursts_done++;
      end
    end

    if (Fifo_ReadEn_out && !Fifo_Empty_in) begin
      check("rd_in_burst", in_burst, 0);
      check("rd_overflow", exp_q.size() < BL, 1);
      w = fifo_q.pop_front();
      exp_q.push_back(w);
      data_next = w;
      have_data = 1;
    end
  endtask

  // ---------------- drivers (posedge + 1) ----------------
  task automatic drive();
    bit ack_drv, fs, strb;
    ack_drv = 0;
    fs      = 0;
    strb    = 0;

    if (have_data) begin
      Fifo_Data_in = data_next;
      have_data    = 0;
    end else begin
      Fifo_Data_in = DW'($urandom_range(0, 16'hFFFF));
    end

    while (fifo_q.size() < 4) begin
      if (seq_mode) begin
        fifo_q.push_back(next_word);
        next_word++;
      end else begin
        fifo_q.push_back(DW'($urandom_range(0, 16'hFFFF)));
      end
    end
    gap_tog = ~gap_tog;
    case (empty_mode)
      1:       Fifo_Empty_in = gap_tog;
      2:       Fifo_Empty_in = ($urandom_range(0, 2) == 0);
      default: Fifo_Empty_in = 1'b0;
    endcase

    if (in_burst && !acked) begin
      wait_cnt++;
      if (fs_req_arm && model_addr == 16) begin
        fs         = 1;
        fs_req_arm = 0;
      end else if (wait_cnt >= ack_delay) begin
        ack_drv = 1;
        if (fs_ack_arm) begin
          fs         = 1;
          fs_ack_arm = 0;
        end
      end
    end
    if (fs_wr_arm && in_burst && acked && sent == 3 && model_addr == 16) begin
      fs        = 1;
      fs_wr_arm = 0;
    end

    if (in_burst && (acked || ack_drv) && sent < BL) begin
      case (strb_mode)
        1:       strb = (strb_phase % 4 == 0);
        2:       strb = ($urandom_range(0, 1) == 1);
        default: strb = 1;
      endcase
      strb_phase++;
    end else if (stray_mode && !in_burst) begin
      strb = ($urandom_range(0, 2) == 0);
    end

    Sdram_WrAck_in     = ack_drv;
    Frame_Start_in     = fs;
    Sdram_WrDataReq_in = strb;
  endtask

  task automatic cycle();
    @(negedge Clk);
    observe();
    @(posedge Clk);
    #1;
    drive();
  endtask

  task automatic run_bursts(input int n);
    int start, t;
    start = bursts_done;
    t = 0;
    while (bursts_done - start < n && t < n * 250) begin
      cycle();
      t++;
    end
    check("burst_timeout", bursts_done - start, n);
    repeat (3) cycle();
    check("done_outstanding", done_exp_q.size(), 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int t;
    seq_mode = 1; stray_mode = 0; rand_ack = 0; gap_tog = 0;
    fs_req_arm = 0; fs_wr_arm = 0; fs_ack_arm = 0;
    empty_mode = 0; strb_mode = 0; strb_phase = 0;
    next_word = 16'h0001;
    bursts_done = 0;
    model_reset();
    do_reset();

    // words 0x0001..0x0008, ack after 2 cycles, continuous strobes
    run_bursts(1);
    seq_mode = 0;

    // FIFO empty every other cycle during fill
    empty_mode = 1;
    run_bursts(1);
    empty_mode = 0;

    // bursts at 16 and 24 close the frame; next request goes back to 0
    run_bursts(2);

    // frame start while the request at 16 waits for its ack
    fs_req_arm = 1;
    run_bursts(3);
    check("fs_req_fired", fs_req_arm, 0);

    // frame start in the middle of the burst at 16
    fs_wr_arm = 1;
    run_bursts(3);
    check("fs_wr_fired", fs_wr_arm, 0);

    // frame start in the same cycle as the ack
    fs_ack_arm = 1;
    run_bursts(2);
    check("fs_ack_fired", fs_ack_arm, 0);

    // gapped strobes plus stray strobes outside bursts
    strb_mode = 1; stray_mode = 1;
    run_bursts(3);

    // randomised soak
    empty_mode = 2; strb_mode = 2; rand_ack = 1;
    run_bursts(6);

    // clear in the middle of a burst
    t = 0;
    while (!(in_burst && acked && sent >= 4) && t < 500) begin
      cycle();
      t++;
    end
    check("mid_burst_reached", in_burst && acked && sent >= 4, 1);
    do_reset();
    empty_mode = 0; strb_mode = 0; stray_mode = 0; rand_ack = 0;
    run_bursts(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
